// File: rtl/svi_operand_driver_if.sv
// SVI link: y/x from driver side, z/w back from responder.
// P1/P2 are responder ports; D is the driver port.
interface I;
  logic y;
  logic x;
  logic z;
  logic w;

  modport P1 (input y, input x, output z, output w);
  modport P2 (input y, input x, output z, output w);
  modport D  (output y, output x, input z, input w);
endinterface

// File: rtl/svi_operand_driver.sv
// Queued operand driver/sampler for the SVI link via I.D.
// Optional in-line and/xor checker: define SVI_DRV_CHECK_EN.
module svi_operand_driver #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_y,
  input  logic             in_x,
  I.D                      d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_z,
  output logic             out_w,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SETTLE + 1);

  generate
    if (SETTLE < 1) begin : g_bad_settle
      $error("SETTLE must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [SW-1:0] cnt;
  logic          dy;
  logic          dx;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          sample;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && !empty;
  assign sample   = (state == WAIT) && (cnt == SW'(1));
  assign busy     = (state != IDLE) || !empty;

  assign d.y = dy;
  assign d.x = dx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      state     <= IDLE;
      cnt       <= '0;
      dy        <= 1'b0;
      dx        <= 1'b0;
      out_valid <= 1'b0;
      out_z     <= 1'b0;
      out_w     <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= {in_y, in_x};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            dy    <= mem[rd_ptr[AW-1:0]][1];
            dx    <= mem[rd_ptr[AW-1:0]][0];
            cnt   <= SW'(SETTLE);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (sample) begin
            out_z     <= d.z;
            out_w     <= d.w;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SVI_DRV_CHECK_EN
  logic mis;
  assign mis = ({d.z, d.w} != {dy & dx, dy ^ dx});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (sample) begin
      err <= mis;
      if (mis && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_svi_operand_driver.sv
// Bench: queue model of the driver with and/xor responders.
// Second instance covers SETTLE=2 and a 2-bit error counter.
module tb_svi_operand_driver;

`ifdef SVI_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic in_valid, in_ready, in_y, in_x;
  logic out_valid, out_ready, out_z, out_w, err, busy;
  logic [15:0] err_cnt;
  logic fault;

  I ifc ();
  assign ifc.z = ifc.y & ifc.x;
  assign ifc.w = fault ? 1'b0 : (ifc.y ^ ifc.x);

  svi_operand_driver #(.DEPTH(DEPTH), .SETTLE(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_x(in_x),
    .d(ifc.D),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_w(out_w),
    .err(err), .err_cnt(err_cnt), .busy(busy)
  );

  logic in_valid2, in_ready2, in_y2, in_x2;
  logic out_valid2, out_ready2, out_z2, out_w2, err2, busy2;
  logic [1:0] err_cnt2;

  I ifc2 ();
  assign ifc2.z = ifc2.y & ifc2.x;
  assign ifc2.w = 1'b0;

  svi_operand_driver #(.DEPTH(2), .SETTLE(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_y(in_y2), .in_x(in_x2),
    .d(ifc2.D),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_z(out_z2), .out_w(out_w2),
    .err(err2), .err_cnt(err_cnt2), .busy(busy2)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", nm, got, exp);
  endtask

  always @(posedge clk) cyc++;

  // model: outstanding pairs in push order, plus saturating mismatch count
  logic [1:0]  q[$];
  logic [1:0]  res_q[$];
  int          rise_t[$];
  logic [15:0] mcnt;
  bit          first;
  int          mn;
  logic [1:0]  mp;
  logic        ez, ew, me;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt  = '0;
      first = 1'b1;
    end else begin
      mn = q.size();
      chk("busy", busy, mn != 0);
      if (mn < DEPTH) chk("in_ready_open", in_ready, 1);
      if (mn == DEPTH + 1) chk("in_ready_full", in_ready, 0);
      if (mn > DEPTH + 1) chk("overflow", mn, DEPTH + 1);
      if (out_valid) begin
        if (mn == 0) begin
          chk("spurious_result", out_valid, 0);
        end else begin
          mp = q[0];
          ez = mp[1] & mp[0];
          ew = fault ? 1'b0 : (mp[1] ^ mp[0]);
          me = CHK && ({ez, ew} != {mp[1] & mp[0], mp[1] ^ mp[0]});
          if (first) begin
            if (me && mcnt != 16'hffff) mcnt = mcnt + 1'b1;
            rise_t.push_back(cyc);
            res_q.push_back({out_z, out_w});
            first = 1'b0;
          end
          chk("out_z", out_z, ez);
          chk("out_w", out_w, ew);
          chk("err", err, me);
          chk("drive_y", ifc.y, mp[1]);
          chk("drive_x", ifc.x, mp[0]);
          if (out_ready) begin
            void'(q.pop_front());
            first = 1'b1;
          end
        end
      end
      chk("err_cnt", err_cnt, mcnt);
      if (in_valid && in_ready) q.push_back({in_y, in_x});
    end
  end

  task automatic push(input logic y, input logic x);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_y = y;
    in_x = x;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || q.size() != 0) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 300) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 50) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    int n, acc, lat;
    logic [1:0] exp_res [4];
    logic [1:0] exp_c2 [5];
    logic ry;
    exp_res = '{2'b00, 2'b01, 2'b01, 2'b10};
    exp_c2  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst_n = 1'b0;
    in_valid = 0; in_y = 0; in_x = 0; out_ready = 0; fault = 0;
    in_valid2 = 0; in_y2 = 0; in_x2 = 0; out_ready2 = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dy", ifc.y, 0);
    chk("rst_dx", ifc.x, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_w", out_w, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single op latency: accept at E0, out_valid after E2
    in_valid = 1; in_y = 1; in_x = 1;
    @(negedge clk);
    chk("t1_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    @(posedge clk);
    #1;
    chk("t1_not_yet", out_valid, 0);
    @(posedge clk);
    #1;
    chk("t1_valid", out_valid, 1);
    chk("t1_z", out_z, 1);
    chk("t1_w", out_w, 0);
    chk("t1_err", err, 0);
    out_ready = 1;
    wait_idle();

    // back-to-back 00,01,10,11 with out_ready high
    rise_t.delete();
    res_q.delete();
    for (int i = 0; i < 4; i++) push(i[1], i[0]);
    wait_idle();
    chk("t2_count", res_q.size(), 4);
    for (int i = 0; i < 4 && i < res_q.size(); i++)
      chk("t2_result", res_q[i], exp_res[i]);
    for (int i = 1; i < rise_t.size(); i++)
      chk("t2_spacing", rise_t[i] - rise_t[i-1], 3);

    // backpressure: 6 offered, 5 accepted
    out_ready = 0;
    acc = 0;
    for (int c = 0; c < 14; c++) begin
      in_valid = (acc < 6);
      in_y = acc[0];
      in_x = acc[1];
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
    end
    chk("t3_accepted", acc, 5);
    chk("t3_in_ready", in_ready, 0);
    out_ready = 1;
    for (int c = 0; c < 60 && acc < 6; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    chk("t3_sixth", acc, 6);
    wait_idle();

    // faulty responder, w stuck at 0
    fault = 1;
    out_ready = 0;
    push(1, 0);
    wait_valid();
    chk("t4_w", out_w, 0);
    chk("t4_err", err, CHK);
    chk("t4_err_cnt", err_cnt, CHK ? 1 : 0);
    out_ready = 1;
    wait_idle();
    fault = 0;

    // reset in WAIT with two pairs queued
    out_ready = 0;
    push(0, 1);
    wait_valid();
    push(1, 1);
    push(1, 1);
    push(1, 0);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    @(posedge clk);
    #1;
    chk("t5_busy_pre", busy, 1);
    chk("t5_dy_pre", ifc.y, 1);
    rst_n = 0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_dy", ifc.y, 0);
    chk("t5_dx", ifc.x, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_emit", out_valid, 0);
    chk("t5_idle", busy, 0);

    // randomized traffic, fault flipped between rounds
    for (int r = 0; r < 3; r++) begin
      fault = (r == 1);
      for (int c = 0; c < 250; c++) begin
        in_valid  = ($urandom_range(0, 99) < 60);
        in_y      = $urandom_range(0, 1);
        in_x      = $urandom_range(0, 1);
        out_ready = ($urandom_range(0, 99) < 65);
        @(posedge clk);
        #1;
      end
      in_valid = 0;
      out_ready = 1;
      wait_idle();
    end
    fault = 0;

    // SETTLE=2, CNT_W=2, every op mismatches when checked
    for (int i = 0; i < 5; i++) begin
      ry = $urandom_range(0, 1);
      in_valid2 = 1; in_y2 = ry; in_x2 = !ry;
      @(negedge clk);
      chk("c2_ready", in_ready2, 1);
      @(posedge clk);
      #1;
      in_valid2 = 0;
      lat = 0;
      while (!out_valid2 && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("c2_latency", lat, 3);
      chk("c2_z", out_z2, 0);
      chk("c2_w", out_w2, 0);
      chk("c2_err", err2, CHK);
      chk("c2_err_cnt", err_cnt2, CHK ? exp_c2[i] : 2'd0);
      @(posedge clk);
      #1;
      chk("c2_drained", out_valid2, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
